imem_responder: RTL and testbench

- Instruction-memory responder that sits on the far side of the fetch stage's PC interface.
- Accepts the fetch address (PCF) as a request, returns the addressed 32-bit instruction word after a configurable number of wait states, and drives a stall line that holds the PC register (the fetch enable equals NOT stall).
- Honours a pipeline redirect flush and provides a program-load write port used by the testbench/boot loader.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/imem_array.sv | 49 ++++
 rtl/imem_responder.sv | 151 +++++++++++++++
 tb/tb_imem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch memory responder.
// Holds the responder state encoding, the instruction word width, the filler
// instruction used when preloading memory, and a small address helper.
package fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int INSTR_WIDTH = 32;

    // ARM "mov r0, r0": harmless filler word for unused memory locations.
    localparam logic [31:0] NOP_WORD = 32'hE1A0_0000;

    // A byte address is word-aligned only when its two low bits are zero.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH x DW words with one synchronous write port and one
// synchronous read port. A read and a write to the same word in the same cycle
// return the old contents (read-before-write). Only the read data register is
// reset; the memory contents are not.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset for the read data register
//   we     write strobe; waddr/wdata give the word index and data
//   re     read strobe; raddr is the word index, rdata updates at the edge
//   rdata  registered read data, holds its value while re is low
module imem_array #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rdata_r;

    // Write port: storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: non-blocking update means a same-edge write is not yet visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder behind the fetch stage's PC interface.
// A request (req with the PC on addr) is accepted in IDLE, the word is read
// after WAIT_STATES extra cycles, and rdata/rvalid are presented one edge
// later. While a request is in progress, stall holds the PC register. A flush
// (redirect) aborts any in-flight request. A load port lets the boot loader
// or bench write program words at any time.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous reset, active-low
//   req, addr     fetch request and byte address (word = addr[WIDTH-1:2])
//   flush         redirect taken; discards any pending request
//   load_en       program-load write strobe with load_addr / load_data
//   rdata         registered instruction word (holds when rvalid is low)
//   rvalid        one-cycle pulse per completed request
//   stall         combinational; high means hold the PC
//   misalign_err  sticky flag, set when a misaligned request is accepted
module imem_responder
    import fetch_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int INSTR_WIDTH = fetch_pkg::INSTR_WIDTH,
    parameter int WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req,
    input  logic [WIDTH-1:0]       addr,
    input  logic                   flush,
    input  logic                   load_en,
    input  logic [WIDTH-1:0]       load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    output logic [INSTR_WIDTH-1:0] rdata,
    output logic                   rvalid,
    output logic                   stall,
    output logic                   misalign_err
);

    localparam int AW    = WIDTH - 2;
    localparam int DEPTH = 2 ** AW;
    // Counter starts at N-1 so the last WAIT cycle (counter==0) performs the read.
    localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t          state_r;
    state_t          state_s;
    logic [2:0]      cnt_r;
    logic [2:0]      cnt_s;
    logic [AW-1:0]   addr_word_r;
    logic            misalign_r;
    logic            rvalid_r;
    logic            accept_s;
    logic            final_s;
    logic            read_fire_s;
    logic            stall_s;
    logic [AW-1:0]   raddr_s;
    logic [1:0]      load_lsb_unused_s;

    // Byte offset of a load is irrelevant: whole words are written.
    assign load_lsb_unused_s = load_addr[1:0];

    // Request acceptance, read strobe, read address and stall decode.
    always_comb begin
        accept_s    = (state_r == IDLE) && req && !flush;
        final_s     = (state_r == WAIT) && (cnt_r == 3'd0);
        // Flush suppresses any read, including a zero-wait read issued this cycle.
        read_fire_s = !flush && (final_s || (accept_s && (WAIT_STATES == 0)));
        if (state_r == WAIT) begin
            raddr_s = addr_word_r;
        end else begin
            raddr_s = addr[WIDTH-1:2];
        end
        // The final WAIT cycle releases the PC so the next request lands right after rvalid.
        stall_s = !flush && (((state_r == IDLE) && req && (WAIT_STATES > 0)) ||
                             ((state_r == WAIT) && (cnt_r != 3'd0)));
    end

    // Next-state and counter logic; flush overrides everything.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        if (flush) begin
            state_s = IDLE;
            cnt_s   = 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && (WAIT_STATES > 0)) begin
                        state_s = WAIT;
                        cnt_s   = CNT_INIT;
                    end else begin
                        state_s = IDLE;
                        cnt_s   = 3'd0;
                    end
                end
                WAIT: begin
                    if (cnt_r == 3'd0) begin
                        state_s = IDLE;
                        cnt_s   = 3'd0;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = 3'd0;
                end
            endcase
        end
    end

    // State, counter, captured address, rvalid pulse and sticky misalignment flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
            addr_word_r <= '0;
            misalign_r  <= 1'b0;
            rvalid_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            rvalid_r <= read_fire_s;
            if (accept_s) begin
                addr_word_r <= addr[WIDTH-1:2];
            end
            if (accept_s && is_misaligned(addr[1:0])) begin
                misalign_r <= 1'b1;
            end
        end
    end

    imem_array #(
        .AW (AW),
        .DW (INSTR_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst_n (reset),
        .we    (load_en),
        .waddr (load_addr[WIDTH-1:2]),
        .wdata (load_data),
        .re    (read_fire_s),
        .raddr (raddr_s),
        .rdata (rdata)
    );

    assign rvalid       = rvalid_r;
    assign stall        = stall_s;
    assign misalign_err = misalign_r;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (zero and two wait states) share the
// clock, reset and load port. A reference model tracks, per instance, the
// cycle at which it is next free; each accepted request becomes an entry
// "word idx read in cycle t+N", resolved against a model memory in that cycle
// and expected as rvalid/rdata in cycle t+N+1. A monitor pops and compares.
module tb_imem_responder;
    import fetch_pkg::*;

    localparam int WS1 = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, flush0, req1, flush1;
    logic [7:0]  addr0, addr1;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] rdata0, rdata1;
    logic        rvalid0, rvalid1, stall0, stall1, mis0, mis1;

    always #5 clk = ~clk;

    imem_responder #(.WIDTH(8), .INSTR_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .addr(addr0), .flush(flush0),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .rdata(rdata0), .rvalid(rvalid0), .stall(stall0), .misalign_err(mis0));

    imem_responder #(.WIDTH(8), .INSTR_WIDTH(32), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .addr(addr1), .flush(flush1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .rdata(rdata1), .rvalid(rvalid1), .stall(stall1), .misalign_err(mis1));

    typedef struct {
        int          dut;
        int          cyc;
        logic [31:0] val;
    } ent_t;

    logic [31:0] model_mem [64];
    int          free_c [2];
    logic        mis_m [2];
    logic [31:0] last_m [2];
    ent_t        pend_q [$];
    ent_t        res_q [$];
    int          cyc = 0;
    logic        pw_en = 1'b0;
    logic [5:0]  pw_idx;
    logic [31:0] pw_data;
    int          checks = 0;
    int          passed = 0;

    function automatic int ws(input int d);
        return (d == 0) ? 0 : WS1;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s dut%0d cyc=%0d actual=%h expected=%h", name, d, cyc, act, exp);
    endtask

    // One clock cycle with the inputs currently driven; updates the model.
    task automatic cycle_go();
        logic       r [2];
        logic       f [2];
        logic [7:0] a [2];
        logic       acc [2];
        logic       st_exp [2];
        ent_t       e;
        r[0] = req0; f[0] = flush0; a[0] = addr0;
        r[1] = req1; f[1] = flush1; a[1] = addr1;
        for (int d = 0; d < 2; d++) begin
            acc[d]    = reset && r[d] && !f[d] && (cyc >= free_c[d]);
            st_exp[d] = reset && !f[d] &&
                        (((cyc >= free_c[d]) && r[d] && (ws(d) > 0)) || (cyc + 2 <= free_c[d]));
            if (f[d] && reset) begin
                for (int i = pend_q.size() - 1; i >= 0; i--)
                    if (pend_q[i].dut == d && pend_q[i].cyc >= cyc) pend_q.delete(i);
                if (free_c[d] > cyc + 1) free_c[d] = cyc + 1;
            end
            if (acc[d]) begin
                e.dut = d; e.cyc = cyc + ws(d); e.val = 32'(a[d][7:2]);
                pend_q.push_back(e);
                free_c[d] = cyc + ws(d) + 1;
            end
        end
        if (load_en) begin
            pw_en = 1'b1; pw_idx = load_addr[7:2]; pw_data = load_data;
        end
        @(negedge clk);
        check("stall", 0, 32'(stall0), 32'(st_exp[0]));
        check("stall", 1, 32'(stall1), 32'(st_exp[1]));
        check("misalign_err", 0, 32'(mis0), 32'(mis_m[0]));
        check("misalign_err", 1, 32'(mis1), 32'(mis_m[1]));
        for (int d = 0; d < 2; d++)
            if (acc[d] && a[d][1:0] != 2'b00) mis_m[d] = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        load_en = 1'b0;
        if (pw_en) model_mem[pw_idx] = pw_data;
        pw_en = 1'b0;
    endtask

    task automatic drive(input logic r0, input logic [7:0] a0, input logic f0,
                         input logic r1, input logic [7:0] a1, input logic f1);
        req0 = r0; addr0 = a0; flush0 = f0;
        req1 = r1; addr1 = a1; flush1 = f1;
        cycle_go();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic set_load(input logic [7:0] la, input logic [31:0] ld);
        load_en = 1'b1; load_addr = la; load_data = ld;
    endtask

    // Assert reset now (asynchronously), check outputs clear at once, release after two cycles.
    task automatic do_reset();
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; flush0 = 1'b0; flush1 = 1'b0; load_en = 1'b0;
        pend_q.delete();
        res_q.delete();
        for (int d = 0; d < 2; d++) begin
            free_c[d] = 0; mis_m[d] = 1'b0; last_m[d] = 32'h0;
        end
        #1;
        check("reset rvalid", 0, 32'(rvalid0), 32'h0);
        check("reset rvalid", 1, 32'(rvalid1), 32'h0);
        check("reset stall", 0, 32'(stall0), 32'h0);
        check("reset stall", 1, 32'(stall1), 32'h0);
        check("reset rdata", 0, rdata0, 32'h0);
        check("reset rdata", 1, rdata1, 32'h0);
        cycle_go();
        cycle_go();
        reset = 1'b1;
    endtask

    // Monitor: per cycle, compare any due response and the hold value, then resolve reads.
    task automatic monitor_step();
        logic        rv;
        logic [31:0] rd;
        int          k;
        ent_t        e;
        for (int d = 0; d < 2; d++) begin
            rv = (d == 0) ? rvalid0 : rvalid1;
            rd = (d == 0) ? rdata0 : rdata1;
            k = -1;
            for (int i = 0; i < res_q.size(); i++)
                if (res_q[i].dut == d && res_q[i].cyc == cyc) k = i;
            if (rv) begin
                if (k < 0) begin
                    check("unexpected rvalid", d, 32'h1, 32'h0);
                end else begin
                    check("rdata", d, rd, res_q[k].val);
                    last_m[d] = res_q[k].val;
                    res_q.delete(k);
                end
            end else begin
                if (k >= 0) begin
                    check("missing rvalid", d, 32'h0, 32'h1);
                    res_q.delete(k);
                end
                check("rdata hold", d, rd, last_m[d]);
            end
            for (int i = pend_q.size() - 1; i >= 0; i--) begin
                if (pend_q[i].dut == d && pend_q[i].cyc == cyc) begin
                    e.dut = d; e.cyc = cyc + 1; e.val = model_mem[pend_q[i].val[5:0]];
                    res_q.push_back(e);
                    pend_q.delete(i);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00;
        load_en = 1'b0; load_addr = 8'h00; load_data = 32'h0;
        for (int d = 0; d < 2; d++) begin
            free_c[d] = 0; mis_m[d] = 1'b0; last_m[d] = 32'h0;
        end
        for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
        @(posedge clk);
        #1;
        do_reset();

        // Preload every word so all reads are well defined.
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            logic [7:0]  ba;
            w = (i % 2 == 0) ? $urandom : NOP_WORD;
            if (i == 0) w = 32'h1111_1111;
            if (i == 1) w = 32'h2222_2222;
            if (i == 2) w = 32'hAABB_CCDD;
            if (i == 4) w = 32'h0000_0000;
            ba = 8'(i * 4);
            set_load(ba, w);
            idle(1);
        end

        // Zero wait states: back-to-back requests, no stall.
        drive(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(3);

        // Two wait states: request held while stalled, then released.
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h08, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h08, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h08, 1'b0);
        idle(3);

        // Flush mid-wait, then a new request right after.
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h0C, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h0C, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0);
        idle(4);

        // Flush on the same cycle as a zero-wait request.
        drive(1'b1, 8'h08, 1'b1, 1'b0, 8'h00, 1'b0);
        idle(2);

        // Misaligned request served from the containing word.
        drive(1'b1, 8'h06, 1'b0, 1'b1, 8'h06, 1'b0);
        idle(4);

        // Read-before-write on the same word, then the new data.
        set_load(8'h10, 32'h0000_0005);
        drive(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(2);

        // Load during WAIT before the final cycle is seen by the read.
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h14, 1'b0);
        set_load(8'h14, 32'hCAFE_F00D);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(3);

        // Reset in the middle of a wait, then the wrap-around address.
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hFC, 1'b0);
        do_reset();
        drive(1'b1, 8'hFC, 1'b0, 1'b1, 8'hFC, 1'b0);
        idle(4);

        // Randomized traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) set_load(8'($urandom), $urandom);
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0);
        end
        idle(6);

        check("pending left", 0, 32'(pend_q.size()), 32'h0);
        check("responses left", 0, 32'(res_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
